// File: rtl/vga_timing_pkg.sv
// Shared constants, phase encoding and helpers for the VGA raster timing generator.
// Defaults describe 640x480@60 with a 25.175 MHz pixel rate.
package vga_timing_pkg;

  localparam int CNT_W = 12;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FRONT  = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BACK   = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FRONT  = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BACK   = 33;

  typedef enum logic [1:0] {
    PH_SYNC   = 2'd0,
    PH_BACK   = 2'd1,
    PH_ACTIVE = 2'd2,
    PH_FRONT  = 2'd3
  } phase_e;

  // Raster phase of the position currently on the output pins.
  typedef struct packed {
    phase_e h_phase;
    phase_e v_phase;
    logic   last_pixel;
  } dbg_t;

  function automatic int total_len(input int sync, input int back,
                                   input int active, input int front);
    return sync + back + active + front;
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster output bundle: sync/enable levels, framebuffer fetch addresses and line/frame pulses.
// No handshake: every signal is a registered level valid each clk; addr_x/addr_y are meaningful
// only while their *_valid qualifier is high, and a fetch is due when both qualifiers are high.
interface vga_timing_gen_if #(parameter int ADDR_W = 10);
  import vga_timing_pkg::*;

  logic              vga_hs;
  logic              vga_vs;
  logic              vga_de;
  logic              addr_x_valid;
  logic [ADDR_W-1:0] addr_x;
  logic              addr_y_valid;
  logic [ADDR_W-1:0] addr_y;
  logic              line_start;
  logic              frame_start;
  dbg_t              dbg;

  modport master (
    output vga_hs, vga_vs, vga_de, addr_x_valid, addr_x,
           addr_y_valid, addr_y, line_start, frame_start, dbg
  );

  modport slave (
    input vga_hs, vga_vs, vga_de, addr_x_valid, addr_x,
          addr_y_valid, addr_y, line_start, frame_start, dbg
  );

endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter with sync/back/active/front decode and a lead-shifted,
// optionally down-scaled fetch address. All decode outputs are combinational from the count.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int SYNC       = 96,
  parameter int BACK       = 48,
  parameter int ACTIVE     = 640,
  parameter int FRONT      = 16,
  parameter int LEAD       = 0,
  parameter int SCALE_LOG2 = 0,
  parameter int ADDR_W     = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              adv_i,
  output logic [CNT_W-1:0]  cnt_o,
  output logic              wrap_o,
  output logic              sync_o,
  output logic              active_o,
  output logic              lead_valid_o,
  output logic [ADDR_W-1:0] lead_addr_o,
  output phase_e            phase_o
);

  localparam int TOTAL = total_len(SYNC, BACK, ACTIVE, FRONT);
  localparam int A0    = SYNC + BACK;
  localparam int L0    = A0 - LEAD;

  localparam logic [CNT_W-1:0] LAST_C = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] SYNC_C = CNT_W'(SYNC);
  localparam logic [CNT_W-1:0] A0_C   = CNT_W'(A0);
  localparam logic [CNT_W-1:0] AEND_C = CNT_W'(A0 + ACTIVE);
  localparam logic [CNT_W-1:0] L0_C   = CNT_W'(L0);
  localparam logic [CNT_W-1:0] LEND_C = CNT_W'(L0 + ACTIVE);

  if (TOTAL > (1 << CNT_W)) begin : g_total_chk
    $error("vga_axis_counter: total length exceeds counter range");
  end
  if (LEAD > BACK) begin : g_lead_chk
    $error("vga_axis_counter: LEAD must not exceed the back porch");
  end
  if (SCALE_LOG2 > 2) begin : g_scale_chk
    $error("vga_axis_counter: SCALE_LOG2 must be 0..2");
  end

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] lead_offs;
  logic [CNT_W-1:0] lead_scaled;

  always_comb begin
    cnt_d = cnt_q;
    if (adv_i) begin
      cnt_d = (cnt_q == LAST_C) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o        = cnt_q;
  assign wrap_o       = adv_i && (cnt_q == LAST_C);
  assign sync_o       = (cnt_q < SYNC_C);
  assign active_o     = (cnt_q >= A0_C) && (cnt_q < AEND_C);
  assign lead_valid_o = (cnt_q >= L0_C) && (cnt_q < LEND_C);

  // The fetch window is the active window moved LEAD pixels earlier.
  assign lead_offs   = cnt_q - L0_C;
  assign lead_scaled = lead_offs >> SCALE_LOG2;
  assign lead_addr_o = lead_valid_o ? ADDR_W'(lead_scaled) : '0;

  always_comb begin
    phase_o = PH_FRONT;
    if (cnt_q < SYNC_C) begin
      phase_o = PH_SYNC;
    end else if (cnt_q < A0_C) begin
      phase_o = PH_BACK;
    end else if (cnt_q < AEND_C) begin
      phase_o = PH_ACTIVE;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: one horizontal and one vertical axis counter feeding a single
// output register stage, so every output shows the same raster position one clk after the count.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE   = DEF_H_ACTIVE,
  parameter int H_FRONT    = DEF_H_FRONT,
  parameter int H_SYNC     = DEF_H_SYNC,
  parameter int H_BACK     = DEF_H_BACK,
  parameter int V_ACTIVE   = DEF_V_ACTIVE,
  parameter int V_FRONT    = DEF_V_FRONT,
  parameter int V_SYNC     = DEF_V_SYNC,
  parameter int V_BACK     = DEF_V_BACK,
  parameter bit HS_POL     = 1'b0,
  parameter bit VS_POL     = 1'b0,
  parameter int LEAD       = 0,
  parameter int SCALE_LOG2 = 0,
  parameter int ADDR_W     = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pix_ce,
  vga_timing_gen_if.master   vga_o
);

  logic [CNT_W-1:0]  hc, vc;
  logic              h_wrap, v_wrap;
  logic              h_sync, v_sync;
  logic              h_active, v_active;
  logic              h_lead_valid, v_lead_valid;
  logic [ADDR_W-1:0] h_addr, v_addr;
  phase_e            h_phase, v_phase;

  vga_axis_counter #(
    .SYNC(H_SYNC), .BACK(H_BACK), .ACTIVE(H_ACTIVE), .FRONT(H_FRONT),
    .LEAD(LEAD), .SCALE_LOG2(SCALE_LOG2), .ADDR_W(ADDR_W)
  ) u_h (
    .clk(clk), .reset(reset), .adv_i(pix_ce),
    .cnt_o(hc), .wrap_o(h_wrap), .sync_o(h_sync), .active_o(h_active),
    .lead_valid_o(h_lead_valid), .lead_addr_o(h_addr), .phase_o(h_phase)
  );

  // Vertical position steps once per completed line; its fetch window never leads.
  vga_axis_counter #(
    .SYNC(V_SYNC), .BACK(V_BACK), .ACTIVE(V_ACTIVE), .FRONT(V_FRONT),
    .LEAD(0), .SCALE_LOG2(SCALE_LOG2), .ADDR_W(ADDR_W)
  ) u_v (
    .clk(clk), .reset(reset), .adv_i(h_wrap),
    .cnt_o(vc), .wrap_o(v_wrap), .sync_o(v_sync), .active_o(v_active),
    .lead_valid_o(v_lead_valid), .lead_addr_o(v_addr), .phase_o(v_phase)
  );

  logic              hs_q, hs_d;
  logic              vs_q, vs_d;
  logic              de_q, de_d;
  logic              axv_q, axv_d;
  logic [ADDR_W-1:0] ax_q, ax_d;
  logic              ayv_q, ayv_d;
  logic [ADDR_W-1:0] ay_q, ay_d;
  logic              ls_q, ls_d;
  logic              fs_q, fs_d;
  dbg_t              dbg_q, dbg_d;

  // Levels hold while the pixel enable is low; the start pulses only fire on a loading clk.
  always_comb begin
    hs_d  = hs_q;
    vs_d  = vs_q;
    de_d  = de_q;
    axv_d = axv_q;
    ax_d  = ax_q;
    ayv_d = ayv_q;
    ay_d  = ay_q;
    ls_d  = 1'b0;
    fs_d  = 1'b0;
    dbg_d = dbg_q;
    if (pix_ce) begin
      hs_d  = h_sync ? HS_POL : ~HS_POL;
      vs_d  = v_sync ? VS_POL : ~VS_POL;
      de_d  = h_active && v_active;
      axv_d = h_lead_valid;
      ax_d  = h_addr;
      ayv_d = v_lead_valid;
      ay_d  = v_addr;
      ls_d  = (hc == '0);
      fs_d  = (hc == '0) && (vc == '0);
      dbg_d = '{h_phase: h_phase, v_phase: v_phase, last_pixel: v_wrap};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hs_q  <= ~HS_POL;
      vs_q  <= ~VS_POL;
      de_q  <= 1'b0;
      axv_q <= 1'b0;
      ax_q  <= '0;
      ayv_q <= 1'b0;
      ay_q  <= '0;
      ls_q  <= 1'b0;
      fs_q  <= 1'b0;
      dbg_q <= '0;
    end else begin
      hs_q  <= hs_d;
      vs_q  <= vs_d;
      de_q  <= de_d;
      axv_q <= axv_d;
      ax_q  <= ax_d;
      ayv_q <= ayv_d;
      ay_q  <= ay_d;
      ls_q  <= ls_d;
      fs_q  <= fs_d;
      dbg_q <= dbg_d;
    end
  end

  assign vga_o.vga_hs       = hs_q;
  assign vga_o.vga_vs       = vs_q;
  assign vga_o.vga_de       = de_q;
  assign vga_o.addr_x_valid = axv_q;
  assign vga_o.addr_x       = ax_q;
  assign vga_o.addr_y_valid = ayv_q;
  assign vga_o.addr_y       = ay_q;
  assign vga_o.line_start   = ls_q;
  assign vga_o.frame_start  = fs_q;
  assign vga_o.dbg          = dbg_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: four parameter sets side by side, a per-clk expected queue fed from a
// raster model, a hand-written table of spot positions, and run-length measurements.
module tb_vga_timing_gen;

  localparam int AW = 10;
  localparam int W  = 27;
  localparam int QW = 2 + 8 + W;

  logic clk = 1'b0;
  logic reset;
  logic pix_ce;

  always #5 clk = ~clk;

  vga_timing_gen_if #(.ADDR_W(AW)) if0();
  vga_timing_gen_if #(.ADDR_W(AW)) if1();
  vga_timing_gen_if #(.ADDR_W(AW)) if2();
  vga_timing_gen_if #(.ADDR_W(AW)) if3();

  vga_timing_gen dut0 (.clk(clk), .reset(reset), .pix_ce(pix_ce), .vga_o(if0));

  vga_timing_gen #(.V_ACTIVE(2), .V_FRONT(1), .V_SYNC(1), .V_BACK(1), .LEAD(4)) dut1 (
    .clk(clk), .reset(reset), .pix_ce(pix_ce), .vga_o(if1));

  vga_timing_gen #(.V_ACTIVE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1), .SCALE_LOG2(1)) dut2 (
    .clk(clk), .reset(reset), .pix_ce(pix_ce), .vga_o(if2));

  vga_timing_gen #(.H_ACTIVE(4), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
                   .V_ACTIVE(2), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
                   .HS_POL(1'b1), .VS_POL(1'b1)) dut3 (
    .clk(clk), .reset(reset), .pix_ce(pix_ce), .vga_o(if3));

  // {hs, vs, de, axv, ax, ayv, ay, ls, fs}
  logic [W-1:0] act [4];
  assign act[0] = {if0.vga_hs, if0.vga_vs, if0.vga_de, if0.addr_x_valid, if0.addr_x,
                   if0.addr_y_valid, if0.addr_y, if0.line_start, if0.frame_start};
  assign act[1] = {if1.vga_hs, if1.vga_vs, if1.vga_de, if1.addr_x_valid, if1.addr_x,
                   if1.addr_y_valid, if1.addr_y, if1.line_start, if1.frame_start};
  assign act[2] = {if2.vga_hs, if2.vga_vs, if2.vga_de, if2.addr_x_valid, if2.addr_x,
                   if2.addr_y_valid, if2.addr_y, if2.line_start, if2.frame_start};
  assign act[3] = {if3.vga_hs, if3.vga_vs, if3.vga_de, if3.addr_x_valid, if3.addr_x,
                   if3.addr_y_valid, if3.addr_y, if3.line_start, if3.frame_start};

  typedef struct {
    int h_sync, h_back, h_act, h_front;
    int v_sync, v_back, v_act, v_front;
    bit hp, vp;
    int lead, scale;
  } prm_t;

  typedef struct {
    int           dut;
    int           kind;  // 0: position loaded on a pix_ce clk, 1: reset clk
    int           hc;
    int           vc;
    logic [W-1:0] exp;
  } vec_t;

  prm_t         prm [4];
  int           mhc [4];
  int           mvc [4];
  logic [W-1:0] held [4];
  vec_t         tbl [$];
  logic [QW-1:0] exp_q [$];

  int n_vec  = 0;
  int n_fail = 0;
  int cyc    = 0;

  function automatic logic [W-1:0] pack(bit hs, bit vs, bit de, bit axv, int ax,
                                        bit ayv, int ay, bit ls, bit fs);
    return {hs, vs, de, axv, AW'(ax), ayv, AW'(ay), ls, fs};
  endfunction

  function automatic void add(int d, int k, int hc, int vc, bit hs, bit vs, bit de,
                              bit axv, int ax, bit ayv, int ay, bit ls, bit fs);
    vec_t v;
    v.dut  = d;
    v.kind = k;
    v.hc   = hc;
    v.vc   = vc;
    v.exp  = pack(hs, vs, de, axv, ax, ayv, ay, ls, fs);
    tbl.push_back(v);
  endfunction

  function automatic logic [W-1:0] reset_vec(int d);
    return pack(!prm[d].hp, !prm[d].vp, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  function automatic logic [W-1:0] model_at(int d, int hc, int vc);
    prm_t p;
    int ha0, va0, l0, ax, ay;
    bit hs, vs, de, axv, ayv;
    p   = prm[d];
    ha0 = p.h_sync + p.h_back;
    va0 = p.v_sync + p.v_back;
    l0  = ha0 - p.lead;
    hs  = (hc < p.h_sync) ? p.hp : !p.hp;
    vs  = (vc < p.v_sync) ? p.vp : !p.vp;
    ayv = (vc >= va0) && (vc < va0 + p.v_act);
    de  = (hc >= ha0) && (hc < ha0 + p.h_act) && ayv;
    axv = (hc >= l0) && (hc < l0 + p.h_act);
    ax  = axv ? ((hc - l0) >> p.scale) : 0;
    ay  = ayv ? ((vc - va0) >> p.scale) : 0;
    return pack(hs, vs, de, axv, ax, ayv, ay, hc == 0, (hc == 0) && (vc == 0));
  endfunction

  task automatic push_exp(int d, int row, logic [W-1:0] e);
    exp_q.push_back({2'(d), 8'(row), e});
  endtask

  task automatic check_int(string name, int got, int want);
    n_vec++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  // Run-length and period measurements taken straight off the pins.
  bit mon_en = 1'b0;
  bit prev_hs0, prev_vs0, prev_axv1, prev_de1;
  int hs_run, vs_run;
  int hs_low_first = -1, hs_high_first = -1, vs_low_first = -1;
  int ls_last = -1, ls_int = -1, ls_int_first = -1;
  int fs3_last = -1, fs3_int = -1;
  int axv1_rise = -1, lead_first = -1;

  task automatic monitor();
    if (act[0][26] == prev_hs0) begin
      hs_run++;
    end else begin
      if (!prev_hs0 && hs_low_first < 0) hs_low_first = hs_run;
      else if (prev_hs0 && hs_low_first >= 0 && hs_high_first < 0) hs_high_first = hs_run;
      hs_run = 1;
    end
    prev_hs0 = act[0][26];
    if (act[0][25] == prev_vs0) begin
      vs_run++;
    end else begin
      if (!prev_vs0 && vs_low_first < 0) vs_low_first = vs_run;
      vs_run = 1;
    end
    prev_vs0 = act[0][25];
    if (act[0][1]) begin
      if (ls_last >= 0) begin
        ls_int = cyc - ls_last;
        if (ls_int_first < 0) ls_int_first = ls_int;
      end
      ls_last = cyc;
    end
    if (act[3][0]) begin
      if (fs3_last >= 0) fs3_int = cyc - fs3_last;
      fs3_last = cyc;
    end
    if (act[1][23] && !prev_axv1) axv1_rise = cyc;
    if (act[1][24] && !prev_de1 && lead_first < 0) lead_first = cyc - axv1_rise;
    prev_axv1 = act[1][23];
    prev_de1  = act[1][24];
  endtask

  task automatic step(input logic r, input logic ce);
    logic [QW-1:0] q;
    logic [W-1:0]  e;
    int            qd, qrow;
    @(negedge clk);
    reset  = r;
    pix_ce = ce;
    for (int d = 0; d < 4; d++) begin
      if (r) begin
        e = reset_vec(d);
        mhc[d] = 0;
        mvc[d] = 0;
        held[d] = e;
        push_exp(d, 0, e);
        for (int i = 0; i < tbl.size(); i++)
          if (tbl[i].dut == d && tbl[i].kind == 1) push_exp(d, i + 1, tbl[i].exp);
      end else if (ce) begin
        e = model_at(d, mhc[d], mvc[d]);
        push_exp(d, 0, e);
        for (int i = 0; i < tbl.size(); i++)
          if (tbl[i].dut == d && tbl[i].kind == 0 && tbl[i].hc == mhc[d] && tbl[i].vc == mvc[d])
            push_exp(d, i + 1, tbl[i].exp);
        held[d] = {e[W-1:2], 2'b00};
        mhc[d]++;
        if (mhc[d] == prm[d].h_sync + prm[d].h_back + prm[d].h_act + prm[d].h_front) begin
          mhc[d] = 0;
          mvc[d]++;
          if (mvc[d] == prm[d].v_sync + prm[d].v_back + prm[d].v_act + prm[d].v_front)
            mvc[d] = 0;
        end
      end else begin
        push_exp(d, 0, held[d]);
      end
    end
    @(posedge clk);
    #1;
    while (exp_q.size() > 0) begin
      q    = exp_q.pop_front();
      qd   = int'(q[QW-1 -: 2]);
      qrow = int'(q[W+7:W]);
      e    = q[W-1:0];
      n_vec++;
      if (act[qd] !== e) begin
        n_fail++;
        $display("FAIL outputs dut%0d row%0d cyc%0d: got %h want %h", qd, qrow, cyc, act[qd], e);
      end
    end
    cyc++;
    if (mon_en) monitor();
  endtask

  initial begin
    prm[0] = '{96, 48, 640, 16, 2, 33, 480, 10, 1'b0, 1'b0, 0, 0};
    prm[1] = '{96, 48, 640, 16, 1, 1, 2, 1, 1'b0, 1'b0, 4, 0};
    prm[2] = '{96, 48, 640, 16, 1, 1, 4, 1, 1'b0, 1'b0, 0, 1};
    prm[3] = '{2, 2, 4, 2, 1, 1, 2, 1, 1'b1, 1'b1, 0, 0};

    //   d  k  hc   vc  hs vs de axv ax   ayv ay ls fs
    add(0, 1, 0,   0,  1, 1, 0, 0, 0,   0, 0, 0, 0);
    add(3, 1, 0,   0,  0, 0, 0, 0, 0,   0, 0, 0, 0);
    add(0, 0, 0,   0,  0, 0, 0, 0, 0,   0, 0, 1, 1);
    add(0, 0, 95,  0,  0, 0, 0, 0, 0,   0, 0, 0, 0);
    add(0, 0, 96,  0,  1, 0, 0, 0, 0,   0, 0, 0, 0);
    add(0, 0, 0,   2,  0, 1, 0, 0, 0,   0, 0, 1, 0);
    add(0, 0, 144, 34, 1, 1, 0, 1, 0,   0, 0, 0, 0);
    add(0, 0, 143, 40, 1, 1, 0, 0, 0,   1, 5, 0, 0);
    add(0, 0, 144, 40, 1, 1, 1, 1, 0,   1, 5, 0, 0);
    add(0, 0, 161, 40, 1, 1, 1, 1, 17,  1, 5, 0, 0);
    add(0, 0, 783, 40, 1, 1, 1, 1, 639, 1, 5, 0, 0);
    add(0, 0, 784, 40, 1, 1, 0, 0, 0,   1, 5, 0, 0);
    add(1, 0, 139, 2,  1, 1, 0, 0, 0,   1, 0, 0, 0);
    add(1, 0, 140, 2,  1, 1, 0, 1, 0,   1, 0, 0, 0);
    add(1, 0, 144, 2,  1, 1, 1, 1, 4,   1, 0, 0, 0);
    add(1, 0, 779, 2,  1, 1, 1, 1, 639, 1, 0, 0, 0);
    add(1, 0, 780, 2,  1, 1, 1, 0, 0,   1, 0, 0, 0);
    add(1, 0, 784, 2,  1, 1, 0, 0, 0,   1, 0, 0, 0);
    add(2, 0, 144, 2,  1, 1, 1, 1, 0,   1, 0, 0, 0);
    add(2, 0, 145, 2,  1, 1, 1, 1, 0,   1, 0, 0, 0);
    add(2, 0, 146, 2,  1, 1, 1, 1, 1,   1, 0, 0, 0);
    add(2, 0, 782, 2,  1, 1, 1, 1, 319, 1, 0, 0, 0);
    add(2, 0, 783, 2,  1, 1, 1, 1, 319, 1, 0, 0, 0);
    add(2, 0, 144, 3,  1, 1, 1, 1, 0,   1, 0, 0, 0);
    add(2, 0, 144, 4,  1, 1, 1, 1, 0,   1, 1, 0, 0);
    add(2, 0, 144, 5,  1, 1, 1, 1, 0,   1, 1, 0, 0);
    add(2, 0, 144, 6,  1, 1, 0, 1, 0,   0, 0, 0, 0);
    add(3, 0, 0,   0,  1, 1, 0, 0, 0,   0, 0, 1, 1);
    add(3, 0, 5,   1,  0, 0, 0, 1, 1,   0, 0, 0, 0);
    add(3, 0, 0,   2,  1, 0, 0, 0, 0,   1, 0, 1, 0);
    add(3, 0, 1,   2,  1, 0, 0, 0, 0,   1, 0, 0, 0);
    add(3, 0, 2,   2,  0, 0, 0, 0, 0,   1, 0, 0, 0);
    add(3, 0, 3,   2,  0, 0, 0, 0, 0,   1, 0, 0, 0);
    add(3, 0, 4,   2,  0, 0, 1, 1, 0,   1, 0, 0, 0);
    add(3, 0, 5,   2,  0, 0, 1, 1, 1,   1, 0, 0, 0);
    add(3, 0, 6,   2,  0, 0, 1, 1, 2,   1, 0, 0, 0);
    add(3, 0, 7,   2,  0, 0, 1, 1, 3,   1, 0, 0, 0);
    add(3, 0, 8,   2,  0, 0, 0, 0, 0,   1, 0, 0, 0);
    add(3, 0, 9,   2,  0, 0, 0, 0, 0,   1, 0, 0, 0);
    add(3, 0, 4,   3,  0, 0, 1, 1, 0,   1, 1, 0, 0);
    add(3, 0, 4,   4,  0, 0, 0, 1, 0,   0, 0, 0, 0);

    reset  = 1'b1;
    pix_ce = 1'b0;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0);

    prev_hs0 = 1'b0;
    prev_vs0 = 1'b0;
    hs_run   = 0;
    vs_run   = 0;
    mon_en   = 1'b1;

    // Full-rate raster: 41 default lines, many small frames.
    for (int i = 0; i < 32800; i++) step(1'b0, 1'b1);
    check_int("hs_low_clks", hs_low_first, 96);
    check_int("hs_high_clks", hs_high_first, 704);
    check_int("line_period", ls_int_first, 800);
    check_int("vs_low_clks", vs_low_first, 1600);
    check_int("small_frame_period", fs3_int, 50);
    check_int("addr_lead_clks", lead_first, 4);

    // Half-rate pixel enable: levels hold between enables, line takes 1600 clks.
    for (int i = 0; i < 3200; i++) step(1'b0, (i % 2) == 0);
    check_int("line_period_half_rate", ls_int, 1600);

    // Reset in the middle of an active line, asserted together with pix_ce.
    for (int i = 0; i < 300; i++) step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1);
    step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA raster timing generator that replaces the separate horizontal and vertical FSM pair with one block. It generates HSYNC/VSYNC with configurable polarity, a display-enable, and framebuffer read addresses that can lead active video by a fixed number of pixels to cover memory latency. An optional power-of-two pixel/line repeat scales the address space down from the raster. It sits between the system clock and the framebuffer reader / DAC output stage.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch, pixels
- H_SYNC, 96, HSYNC pulse width, pixels
- H_BACK, 48, horizontal back porch, pixels
- V_ACTIVE, 480, visible lines
- V_FRONT, 10, vertical front porch, lines
- V_SYNC, 2, VSYNC pulse width, lines
- V_BACK, 33, vertical back porch, lines
- HS_POL, 0, HSYNC active level (0 = active-low)
- VS_POL, 0, VSYNC active level
- LEAD, 0, pixels by which addr_x leads vga_de; legal range 0..H_BACK
- SCALE_LOG2, 0, address = raster position >> SCALE_LOG2 (0 to 2)
- ADDR_W, 10, width of addr_x/addr_y
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- pix_ce  in  1  pixel clock enable; raster advances one pixel per cycle with pix_ce=1
- vga_hs  out  1  horizontal sync
- vga_vs  out  1  vertical sync
- vga_de  out  1  display enable (visible pixel)
- addr_x_valid  out  1  addr_x is a visible column (LEAD-shifted)
- addr_x  out  ADDR_W  column address
- addr_y_valid  out  1  current line is visible
- addr_y  out  ADDR_W  row address
- line_start  out  1  one-clk pulse at start of every line
- frame_start  out  1  one-clk pulse at start of every frame

## Operation
- Internal counters hc (0..H_TOTAL-1) and vc (0..V_TOTAL-1); H_TOTAL = H_SYNC+H_BACK+H_ACTIVE+H_FRONT, V_TOTAL likewise.
- Phase order per axis: sync, back porch, active, front porch. HA0 = H_SYNC+H_BACK, VA0 = V_SYNC+V_BACK.
- On a pix_ce cycle: output registers load from (hc,vc); then hc increments; at H_TOTAL-1 it wraps to 0 and vc increments; vc wraps at V_TOTAL-1.
- vga_hs = HS_POL when hc < H_SYNC, else ~HS_POL. vga_vs likewise on vc.
- vga_de = 1 when hc in [HA0, HA0+H_ACTIVE) and vc in [VA0, VA0+V_ACTIVE).
- addr_x_valid = 1 when hc in [HA0-LEAD, HA0-LEAD+H_ACTIVE); addr_x = (hc-(HA0-LEAD)) >> SCALE_LOG2, else 0.
- addr_y_valid = 1 when vc in [VA0, VA0+V_ACTIVE) for the whole line; addr_y = (vc-VA0) >> SCALE_LOG2, else 0.
- addr_x_valid is independent of vertical phase; consumers fetch on addr_x_valid & addr_y_valid.
- line_start = 1 for the single clk in which outputs load hc=0; frame_start additionally requires vc=0.
- Elaboration check fails if LEAD > H_BACK, SCALE_LOG2 > 2, or H_TOTAL/V_TOTAL exceeds counter range.

## Timing
- Reset values: hc=vc=0; vga_hs=~HS_POL, vga_vs=~VS_POL; vga_de, addr_x_valid, addr_y_valid, line_start, frame_start = 0; addr_x=addr_y=0.
- First pix_ce after reset: outputs show position (0,0): both syncs active, frame_start=line_start=1.
- Output latency: one clk from counter position to output pins; all outputs mutually aligned.
- With pix_ce=0: all level outputs hold; line_start/frame_start are 0.
- pix_ce tied high: one pixel per clk; pulses last exactly one clk.
- Reset mid-frame: next edge applies reset values; raster restarts at (0,0) on the following pix_ce.
- reset has priority over pix_ce in the same cycle.

## Structure
- Package vga_timing_pkg: default 640x480@60 constants, total-length function, phase enum (SYNC, BACK, ACTIVE, FRONT).
- Sub-module vga_axis_counter instantiated twice (horizontal advanced by pix_ce, vertical by horizontal wrap & pix_ce); params SYNC/BACK/ACTIVE/FRONT/LEAD; outputs wrap, sync, active, lead_valid, lead_addr.

## Test plan
- Defaults, pix_ce=1, reset released: vga_hs low 96 clks, high 704; line period 800 clks; vga_vs low 2 lines (1600 clks); frame 525 lines = 420000 clks; frame_start once per frame.
- Defaults: line VA0+5 → addr_y_valid=1, addr_y=5; hc=HA0+17 → vga_de=1, addr_x=17; addr_x_valid low 144 clks before active.
- LEAD=4: addr_x_valid rises 4 clks before vga_de; addr_x=0 at vga_de−4, addr_x=639 at last pixel−4.
- SCALE_LOG2=1: addr_x steps 0,0,1,1,...,319,319; addr_y repeats each row twice, max 239.
- HS_POL=VS_POL=1, small raster (H 4/2/2/2, V 2/1/1/1): syncs active-high, reset values low, exact per-clk phase sequence.
- pix_ce every 2nd clk: line = 1600 clks, outputs hold between enables; reset asserted mid-active-line → outputs at reset values next clk, next pix_ce gives frame_start=1.
